// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants, entry type and helpers for the fetch stage
package fetch_unit_pkg;

    localparam logic [31:0] FETCH_RESET_VECTOR = 32'h0000_0000;
    localparam int          INSTR_BYTES        = 4;
    localparam int          FETCH_BUFFER_DEPTH = 2;

    // One buffered fetch response: the address it was read from and the word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory read port between fetch and memory
// master: fetch side (drives address/request, receives ready/data/data_valid)
// slave:  memory side
interface fetch_unit_if;
    logic [31:0] fetch_address;
    logic        fetch_request;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        fetch_data_valid;

    modport master (
        output fetch_address,
        output fetch_request,
        input  fetch_ready,
        input  fetch_data,
        input  fetch_data_valid
    );

    modport slave (
        input  fetch_address,
        input  fetch_request,
        output fetch_ready,
        output fetch_data,
        output fetch_data_valid
    );
endinterface

// File: rtl/fetch_unit_buffer.sv
// rtl/fetch_unit_buffer.sv - synchronous FIFO of {pc, instr} fetch responses
// Ports: clk, reset_n (async active-low), push/push_data, pop/head,
//        flush (empties the FIFO, wins over a same-cycle push), full, empty, count.
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = FETCH_BUFFER_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           pop_ok;
    logic           push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = mem[rd_ptr];
    assign pop_ok  = pop & ~empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage feeding decode
// Ports: clk, reset_n (async active-low); fetch_bus (memory read port, master);
//        stall (hold outputs), branch_taken/branch_address, trap/trap_address
//        (redirects, trap has priority); pc_out, next_pc_out, instruction_out,
//        valid_out (registered decode-facing outputs).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = FETCH_RESET_VECTOR,
    parameter int          BUFFER_DEPTH = FETCH_BUFFER_DEPTH
) (
    input  logic         clk,
    input  logic         reset_n,
    fetch_unit_if.master fetch_bus,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [31:0]  branch_address,
    input  logic         trap,
    input  logic [31:0]  trap_address,
    output logic [31:0]  pc_out,
    output logic [31:0]  next_pc_out,
    output logic [31:0]  instruction_out,
    output logic         valid_out
);
    localparam int CW = $clog2(BUFFER_DEPTH) + 1;

    logic [31:0]  pc;
    logic [31:0]  inflight_pc;
    logic         outstanding;
    logic         discard;

    logic         redirect;
    logic [31:0]  redirect_target;
    logic         load;
    logic         response;
    logic         buf_push;
    logic         buf_pop;
    logic         buf_full;
    logic         buf_empty;
    logic [CW-1:0] buf_count;
    logic         buf_room;
    logic         accept;
    fetch_entry_t buf_head;

    assign redirect        = trap | branch_taken;
    assign redirect_target = align_word(trap ? trap_address : branch_address);
    assign load            = ~redirect & (~stall | ~valid_out);
    assign response        = outstanding & fetch_bus.fetch_data_valid;
    assign buf_push        = response & ~discard & ~redirect;
    assign buf_pop         = load & ~buf_empty;

    // A new request may only issue if its response is guaranteed a slot once
    // this edge's push/pop have settled. Crediting the same-cycle pop is what
    // lets a two-entry buffer sustain one instruction per cycle.
    always_comb begin
        buf_room = 1'b0;
        if (buf_full)
            buf_room = buf_pop & ~buf_push;
        else
            buf_room = ~((buf_count == CW'(BUFFER_DEPTH - 1)) & buf_push & ~buf_pop);
    end

    assign fetch_bus.fetch_request = reset_n & ~redirect
                                   & (~outstanding | fetch_bus.fetch_data_valid)
                                   & buf_room;
    assign fetch_bus.fetch_address = pc;
    assign accept = fetch_bus.fetch_request & fetch_bus.fetch_ready;

    fetch_buffer #(.DEPTH(BUFFER_DEPTH)) u_buffer (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (buf_push),
        .push_data ('{pc: inflight_pc, instr: fetch_bus.fetch_data}),
        .pop       (buf_pop),
        .flush     (redirect),
        .head      (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc              <= RESET_VECTOR;
            inflight_pc     <= '0;
            outstanding     <= 1'b0;
            discard         <= 1'b0;
            pc_out          <= '0;
            next_pc_out     <= '0;
            instruction_out <= '0;
            valid_out       <= 1'b0;
        end else begin
            if (redirect) begin
                pc <= redirect_target;
            end else if (accept) begin
                pc          <= pc + 32'(INSTR_BYTES);
                inflight_pc <= pc;
            end

            if (accept)        outstanding <= 1'b1;
            else if (response) outstanding <= 1'b0;

            // A redirect with a read still in flight must swallow its response.
            if (response)                     discard <= 1'b0;
            else if (redirect && outstanding) discard <= 1'b1;

            if (redirect) begin
                valid_out <= 1'b0;
            end else if (load) begin
                if (!buf_empty) begin
                    pc_out          <= buf_head.pc;
                    next_pc_out     <= buf_head.pc + 32'(INSTR_BYTES);
                    instruction_out <= buf_head.instr;
                    valid_out       <= 1'b1;
                end else begin
                    valid_out <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] KEY   = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall, branch_taken, trap;
    logic [31:0] branch_address, trap_address;
    logic [31:0] pc_out, next_pc_out, instruction_out;
    logic        valid_out;

    fetch_unit_if bus();

    fetch_unit #(.RESET_VECTOR(32'h0), .BUFFER_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .fetch_bus       (bus),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_address  (branch_address),
        .trap            (trap),
        .trap_address    (trap_address),
        .pc_out          (pc_out),
        .next_pc_out     (next_pc_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model and stream-level reference.
    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t       pend[$];
    int          cyc = 0;
    int          lat = 1;
    bit          ready_i = 1'b1;
    bit          inj_valid = 1'b0;
    logic [31:0] inj_data;
    logic [31:0] exp_pc;      // pc of the next instruction decode should be shown
    logic [31:0] exp_req;     // address of the next read memory should accept
    int          presented = 0;
    bit          s_req, s_acc;
    logic [31:0] s_addr;

    // Runs one clock cycle starting and ending just after a falling edge.
    task automatic cycle();
        logic        redir, pre_valid, pre_stall;
        logic [31:0] tgt, hp, hn, hi;
        bus.fetch_ready      = ready_i;
        bus.fetch_data_valid = 1'b0;
        bus.fetch_data       = $urandom();
        if (inj_valid) begin
            bus.fetch_data_valid = 1'b1;
            bus.fetch_data       = inj_data;
            inj_valid            = 1'b0;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.fetch_data_valid = 1'b1;
            bus.fetch_data       = pend[0].addr ^ KEY;
            void'(pend.pop_front());
        end
        #4;
        s_req  = bus.fetch_request;
        s_addr = bus.fetch_address;
        s_acc  = s_req & ready_i;
        redir  = trap | branch_taken;
        tgt    = (trap ? trap_address : branch_address) & ~32'h3;
        pre_valid = valid_out;
        pre_stall = stall;
        hp = pc_out; hn = next_pc_out; hi = instruction_out;
        if (redir) check("req_during_redirect", 32'(s_req), 32'd0);
        if (s_acc) begin
            check("accepted_addr", s_addr, exp_req);
            exp_req = exp_req + 32'd4;
            pend.push_back('{s_addr, cyc + lat});
        end
        @(posedge clk);
        #1;
        check("fifo_push_when_full",
              32'(dut.u_buffer.push & dut.u_buffer.full & ~dut.u_buffer.pop), 32'd0);
        if (redir) begin
            check("valid_after_redirect", 32'(valid_out), 32'd0);
            exp_pc  = tgt;
            exp_req = tgt;
        end else if (pre_valid && pre_stall) begin
            check("hold_valid", 32'(valid_out), 32'd1);
            check("hold_pc", pc_out, hp);
            check("hold_next", next_pc_out, hn);
            check("hold_instr", instruction_out, hi);
        end else if (valid_out) begin
            check("stream_pc", pc_out, exp_pc);
            check("stream_next", next_pc_out, exp_pc + 32'd4);
            check("stream_instr", instruction_out, exp_pc ^ KEY);
            exp_pc = exp_pc + 32'd4;
            presented++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            cycle();
            ok = s_acc;
        end
        check("wait_accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            cycle();
            ok = valid_out;
        end
        check("wait_valid_timeout", 32'(ok), 32'd1);
    endtask

    typedef struct {
        bit          stall;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_next;
    } vec_t;
    vec_t tab[8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int acc_cnt;
        logic [31:0] a0;

        // Startup from reset: memory always ready, 1-cycle response latency.
        tab[0] = '{0, 1, 32'd0,  0, 32'd0,  32'd0};
        tab[1] = '{0, 1, 32'd4,  0, 32'd0,  32'd0};
        tab[2] = '{0, 1, 32'd8,  1, 32'd0,  32'd4};
        tab[3] = '{0, 1, 32'd12, 1, 32'd4,  32'd8};
        tab[4] = '{0, 1, 32'd16, 1, 32'd8,  32'd12};
        tab[5] = '{0, 1, 32'd20, 1, 32'd12, 32'd16};
        tab[6] = '{1, 0, 32'd24, 1, 32'd12, 32'd16};
        tab[7] = '{0, 1, 32'd24, 1, 32'd16, 32'd20};

        reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; trap = 1'b0;
        branch_address = '0; trap_address = '0;
        bus.fetch_ready = 1'b0; bus.fetch_data_valid = 1'b0; bus.fetch_data = '0;
        @(negedge clk); @(negedge clk);
        check("reset_valid", 32'(valid_out), 32'd0);
        check("reset_pc_out", pc_out, 32'd0);
        check("reset_next_pc", next_pc_out, 32'd0);
        check("reset_instr", instruction_out, 32'd0);
        check("reset_request", 32'(bus.fetch_request), 32'd0);
        check("reset_address", bus.fetch_address, 32'd0);

        reset_n = 1'b1; exp_pc = '0; exp_req = '0;
        for (int i = 0; i < 8; i++) begin
            stall = tab[i].stall;
            cycle();
            check($sformatf("vec%0d_req", i), 32'(s_req), 32'(tab[i].exp_req));
            check($sformatf("vec%0d_addr", i), s_addr, tab[i].exp_addr);
            check($sformatf("vec%0d_valid", i), 32'(valid_out), 32'(tab[i].exp_valid));
            check($sformatf("vec%0d_pc", i), pc_out, tab[i].exp_pc);
            check($sformatf("vec%0d_next", i), next_pc_out, tab[i].exp_next);
        end
        stall = 1'b0;

        // Long stall while streaming.
        for (int i = 0; i < 4; i++) cycle();
        stall = 1'b1; acc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (s_acc) acc_cnt++;
        end
        check("stall_req_dropped", 32'(s_req), 32'd0);
        check("stall_accepts_bounded", 32'(acc_cnt <= DEPTH), 32'd1);
        stall = 1'b0;
        for (int i = 0; i < 8; i++) cycle();

        // Branch to a misaligned target while a 2-cycle read is in flight.
        lat = 2;
        wait_accept();
        branch_taken = 1'b1; branch_address = 32'h103;
        cycle();
        branch_taken = 1'b0;
        wait_valid();
        check("branch_first_pc", pc_out, 32'h100);
        lat = 1;

        // Trap and branch together under stall: trap wins.
        for (int i = 0; i < 3; i++) cycle();
        wait_valid();
        stall = 1'b1; trap = 1'b1; trap_address = 32'h200;
        branch_taken = 1'b1; branch_address = 32'h300;
        cycle();
        stall = 1'b0; trap = 1'b0; branch_taken = 1'b0;
        wait_valid();
        check("trap_first_pc", pc_out, 32'h200);

        // Memory not ready for 4 cycles.
        for (int i = 0; i < 4; i++) cycle();
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (i == 0) a0 = s_addr;
            check("notready_req_high", 32'(s_req), 32'd1);
            check("notready_addr_held", s_addr, a0);
        end
        check("notready_drained", 32'(valid_out), 32'd0);
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) cycle();

        // Randomized traffic against the stream model.
        presented = 0;
        for (int i = 0; i < 300; i++) begin
            stall        = ($urandom_range(3) == 0);
            ready_i      = ($urandom_range(3) != 0);
            lat          = 1 + $urandom_range(2);
            branch_taken = ($urandom_range(19) == 0);
            branch_address = $urandom();
            trap         = ($urandom_range(29) == 0);
            trap_address = $urandom();
            cycle();
        end
        stall = 1'b0; branch_taken = 1'b0; trap = 1'b0; ready_i = 1'b1; lat = 1;
        check("random_progress", 32'(presented > 10), 32'd1);
        for (int i = 0; i < 6; i++) cycle();

        // Asynchronous reset with a read outstanding, late response afterwards.
        lat = 2;
        wait_accept();
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(valid_out), 32'd0);
        check("async_reset_pc", pc_out, 32'd0);
        check("async_reset_next", next_pc_out, 32'd0);
        check("async_reset_instr", instruction_out, 32'd0);
        check("async_reset_req", 32'(bus.fetch_request), 32'd0);
        pend.delete();
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1; exp_pc = '0; exp_req = '0; lat = 1;
        inj_valid = 1'b1; inj_data = 32'hDEAD_BEEF;
        wait_valid();
        check("restart_pc", pc_out, 32'd0);
        check("restart_instr", instruction_out, KEY);
        for (int i = 0; i < 6; i++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
